// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared types and constants for the Wishbone slave responder
// Purpose: FSM state type, request-entry width helper and timeout counter width.
// Ports: none (package).
package wb_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int WB_DATA_W     = 32;
  localparam int WB_SEL_W      = 4;
  localparam int TIMEOUT_CNT_W = 8;

  // A buffered request is packed as {we, sel, adr, data}.
  function automatic int entry_width(input int addr_w);
    return 1 + WB_SEL_W + addr_w + WB_DATA_W;
  endfunction

endpackage

// File: rtl/wb_request_fifo.sv
// rtl/wb_request_fifo.sv - synchronous request FIFO with flush and occupancy count
// Purpose: buffers accepted Wishbone requests; head entry visible combinationally.
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_push/i_data write one entry (caller guarantees not full)
//   i_pop         retire the head entry (caller guarantees not empty)
//   i_flush       discard all entries at the next edge
//   o_head        current head entry
//   o_count       number of stored entries (0..DEPTH)
module wb_request_fifo #(
  parameter int WIDTH = 61,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_slave_interface.sv
// rtl/wb_slave_interface.sv - pipelined Wishbone slave replaying requests onto an enable/busy port
// Purpose: buffers Wishbone requests, executes them one at a time on the peripheral
//   port, returns one ack or error per request; unmapped and hung accesses error.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i/sel_i    Wishbone request; wb_data_i write data, wb_adr_i byte address
//   wb_ack_o/error_o/data_o      response pulse and read data; wb_stall_o = buffer full
//   peripheral*                  word-aligned address, byte select, read/write enables,
//                                write data, read data in, busy in
module wb_slave_interface
  import wb_slave_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int FIFO_DEPTH     = 2,
  parameter int MAPPED_BYTES   = 4096,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_data_i,
  input  logic [ADDRESS_WIDTH-1:0] wb_adr_i,
  output logic                     wb_ack_o,
  output logic                     wb_stall_o,
  output logic                     wb_error_o,
  output logic [31:0]              wb_data_o,
  output logic [ADDRESS_WIDTH-1:0] peripheralAddress,
  output logic [3:0]               peripheralByteSelect,
  output logic                     peripheralWriteEnable,
  output logic                     peripheralReadEnable,
  output logic [31:0]              peripheralDataWrite,
  input  logic [31:0]              peripheralDataRead,
  input  logic                     peripheralBusy
);

  localparam int ENTRY_W = entry_width(ADDRESS_WIDTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]         FULL_COUNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_VAL = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [63:0]              MAPPED_LIM  = 64'(MAPPED_BYTES);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [TIMEOUT_CNT_W-1:0]   r_busy_cnt;
  logic                       r_ack;
  logic                       r_err;
  logic [31:0]                r_rdata;

  logic                       w_accept;
  logic [ENTRY_W-1:0]         w_head;
  logic [CNT_W-1:0]           w_count;
  logic                       w_head_we;
  logic [3:0]                 w_head_sel;
  logic [ADDRESS_WIDTH-1:0]   w_head_adr;
  logic [31:0]                w_head_data;
  logic                       w_unmapped;
  logic                       w_timeout;
  logic                       w_rd_en;
  logic                       w_wr_en;
  logic                       w_pop;
  logic                       w_complete;
  logic                       w_fail;
  logic                       w_drive;

  // Stall comes only from the registered count: a slot freed by a pop this
  // cycle is not offered to the master until the next cycle.
  assign wb_stall_o = (w_count == FULL_COUNT);
  assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  wb_request_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (~wb_cyc_i),
    .i_data  ({wb_we_i, wb_sel_i, wb_adr_i, wb_data_i}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_head_we   = w_head[ENTRY_W-1];
  assign w_head_sel  = w_head[ENTRY_W-2 -: 4];
  assign w_head_adr  = w_head[32 +: ADDRESS_WIDTH];
  assign w_head_data = w_head[31:0];
  assign w_unmapped  = (64'(w_head_adr) >= MAPPED_LIM);
  // The counter only advances while enabled and busy, so reaching the limit
  // means the peripheral has been stuck for TIMEOUT_CYCLES cycles.
  assign w_timeout   = (r_busy_cnt == TIMEOUT_VAL);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_pop        = 1'b0;
    w_complete   = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (w_count != '0) begin
          if (w_unmapped || w_timeout) begin
            w_pop  = 1'b1;
            w_fail = 1'b1;
          end else begin
            w_wr_en = w_head_we;
            w_rd_en = ~w_head_we;
            if (!peripheralBusy) begin
              w_pop      = 1'b1;
              w_complete = 1'b1;
            end
          end
        end
        if (!w_accept && (w_count == CNT_W'(w_pop))) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Dropping cyc abandons everything, including the peripheral access in flight.
    if (!wb_cyc_i) begin
      w_state_next = IDLE;
      w_rd_en      = 1'b0;
      w_wr_en      = 1'b0;
      w_pop        = 1'b0;
      w_complete   = 1'b0;
      w_fail       = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wb_cyc_i || w_pop) begin
      r_busy_cnt <= '0;
    end else if ((w_rd_en || w_wr_en) && peripheralBusy) begin
      r_busy_cnt <= r_busy_cnt + TIMEOUT_CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_complete;
      r_err   <= w_fail;
      r_rdata <= (w_complete && w_rd_en) ? peripheralDataRead : '0;
    end
  end

  // A response registered just before cyc drops is withheld from the master.
  assign wb_ack_o   = r_ack & wb_cyc_i;
  assign wb_error_o = r_err & wb_cyc_i;
  assign wb_data_o  = wb_cyc_i ? r_rdata : '0;

  assign w_drive               = w_rd_en | w_wr_en;
  assign peripheralReadEnable  = w_rd_en;
  assign peripheralWriteEnable = w_wr_en;
  assign peripheralAddress     = w_drive ? {w_head_adr[ADDRESS_WIDTH-1:2], 2'b00} : '0;
  assign peripheralByteSelect  = w_drive ? w_head_sel : '0;
  assign peripheralDataWrite   = w_drive ? w_head_data : '0;

endmodule

// File: tb/tb_wb_slave_interface.sv
// tb/tb_wb_slave_interface.sv - self-checking bench for wb_slave_interface
module tb_wb_slave_interface;

  localparam int AW = 24;

  typedef struct packed {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [31:0]   data;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic          clk;
  logic          rst;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [31:0]   wdat;
  logic [AW-1:0] adr;
  logic          ack;
  logic          stall;
  logic          err;
  logic [31:0]   dout;
  logic [AW-1:0] p_adr;
  logic [3:0]    p_sel;
  logic          p_we;
  logic          p_re;
  logic [31:0]   p_wdat;
  logic [31:0]   rdat;
  logic          busy;

  wb_slave_interface #(
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (2),
    .MAPPED_BYTES  (4096),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .wb_clk_i              (clk),
    .wb_rst_i              (rst),
    .wb_cyc_i              (cyc),
    .wb_stb_i              (stb),
    .wb_we_i               (we),
    .wb_sel_i              (sel),
    .wb_data_i             (wdat),
    .wb_adr_i              (adr),
    .wb_ack_o              (ack),
    .wb_stall_o            (stall),
    .wb_error_o            (err),
    .wb_data_o             (dout),
    .peripheralAddress     (p_adr),
    .peripheralByteSelect  (p_sel),
    .peripheralWriteEnable (p_we),
    .peripheralReadEnable  (p_re),
    .peripheralDataWrite   (p_wdat),
    .peripheralDataRead    (rdat),
    .peripheralBusy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_model(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0; adr = '0;
  endtask

  task automatic put_req(input logic w, input logic [3:0] s, input logic [AW-1:0] a,
                         input logic [31:0] d);
    stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; busy = 1'b0; rdat = 32'hFFFF_FFFF; idle_bus();
    tick(); tick(); sample();
    n_cmp++;
    if ({ack, err, stall, p_re, p_we} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {ack, err, stall, p_re, p_we}); n_fail++;
    end
    n_cmp++;
    if ({dout, p_adr, p_sel, p_wdat} !== '0) begin
      $display("FAIL reset_buses: got %h expected 0", {dout, p_adr, p_sel, p_wdat}); n_fail++;
    end
    tick(); rst = 1'b0; cyc = 1'b1; sample();
    n_cmp++;
    if ({ack, err, stall, p_re, p_we} !== 5'b0) begin
      $display("FAIL post_reset_idle: got %b expected 00000", {ack, err, stall, p_re, p_we}); n_fail++;
    end
  endtask

  task automatic test_read_zero_wait();
    tick(); busy = 1'b0; rdat = 32'hDEAD_BEEF; put_req(1'b0, 4'hF, 24'h000010, 32'h0);
    sample();
    tick(); idle_bus(); sample();
    n_cmp++;
    if ({p_re, p_we, p_adr, ack} !== {1'b1, 1'b0, 24'h000010, 1'b0}) begin
      $display("FAIL read_enable_cycle1: got re=%b we=%b adr=%h ack=%b expected re=1 we=0 adr=000010 ack=0",
               p_re, p_we, p_adr, ack); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({ack, err, dout, p_re} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      $display("FAIL read_ack_cycle2: got ack=%b err=%b data=%h re=%b expected ack=1 err=0 data=deadbeef re=0",
               ack, err, dout, p_re); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if (ack !== 1'b0) begin
      $display("FAIL read_ack_single: got %b expected 0", ack); n_fail++;
    end
  endtask

  task automatic test_write_busy();
    int en = 0;
    tick(); busy = 1'b1; put_req(1'b1, 4'b0011, 24'h000104, 32'h1234_5678); sample();
    tick(); idle_bus();
    for (int i = 0; i < 4; i++) begin
      busy = (i < 3);
      sample();
      if (p_we && p_sel == 4'b0011 && p_wdat == 32'h1234_5678 && p_adr == 24'h000104) en++;
      n_cmp++;
      if (ack !== 1'b0) begin
        $display("FAIL write_early_ack: cycle %0d got ack=%b expected 0", i, ack); n_fail++;
      end
      tick();
    end
    sample();
    n_cmp++;
    if (en !== 4) begin
      $display("FAIL write_enable_cycles: got %0d expected 4", en); n_fail++;
    end
    n_cmp++;
    if ({ack, err, dout, p_we} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      $display("FAIL write_ack: got ack=%b err=%b data=%h we=%b expected ack=1 err=0 data=0 we=0",
               ack, err, dout, p_we); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    busy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 4) put_req(1'b0, 4'hF, 24'(32'h80 + 4 * i), 32'h0);
      else idle_bus();
      rdat = rd_model(p_adr);
      sample();
      n_cmp++;
      if (stall !== 1'b0) begin
        $display("FAIL b2b_stall: cycle %0d got %b expected 0", i, stall); n_fail++;
      end
      if (i >= 2 && i < 6) begin
        n_cmp++;
        if ({ack, dout} !== {1'b1, rd_model(24'(32'h80 + 4 * (i - 2)))}) begin
          $display("FAIL b2b_ack: cycle %0d got ack=%b data=%h expected ack=1 data=%h",
                   i, ack, dout, rd_model(24'(32'h80 + 4 * (i - 2)))); n_fail++;
        end
      end
    end
  endtask

  task automatic test_pipelined_stall();
    tick(); busy = 1'b1; put_req(1'b1, 4'hF, 24'h000200, 32'hA); sample();
    tick(); put_req(1'b1, 4'hF, 24'h000204, 32'hB); sample();
    n_cmp++;
    if (stall !== 1'b0) begin
      $display("FAIL pipe_stall_one: got %b expected 0", stall); n_fail++;
    end
    tick(); put_req(1'b1, 4'hF, 24'h000208, 32'hC); sample();
    n_cmp++;
    if (stall !== 1'b1) begin
      $display("FAIL pipe_stall_full: got %b expected 1", stall); n_fail++;
    end
    tick(); sample();
    tick(); busy = 1'b0; sample();
    n_cmp++;
    if ({stall, p_we, p_adr, ack} !== {1'b1, 1'b1, 24'h000200, 1'b0}) begin
      $display("FAIL pipe_first_complete: got stall=%b we=%b adr=%h ack=%b expected 1 1 000200 0",
               stall, p_we, p_adr, ack); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({stall, ack, p_adr} !== {1'b0, 1'b1, 24'h000204}) begin
      $display("FAIL pipe_second: got stall=%b ack=%b adr=%h expected 0 1 000204", stall, ack, p_adr); n_fail++;
    end
    tick(); idle_bus(); sample();
    n_cmp++;
    if ({ack, p_adr, p_wdat} !== {1'b1, 24'h000208, 32'hC}) begin
      $display("FAIL pipe_third: got ack=%b adr=%h data=%h expected 1 000208 0000000c", ack, p_adr, p_wdat); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({ack, p_we} !== 2'b10) begin
      $display("FAIL pipe_last_ack: got ack=%b we=%b expected 1 0", ack, p_we); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if (ack !== 1'b0) begin
      $display("FAIL pipe_no_extra_ack: got %b expected 0", ack); n_fail++;
    end
  endtask

  task automatic test_unmapped();
    tick(); busy = 1'b0; rdat = 32'h5555_AAAA; put_req(1'b0, 4'hF, 24'h001000, 32'h0); sample();
    tick(); idle_bus(); sample();
    n_cmp++;
    if ({p_re, p_we, ack, err} !== 4'b0) begin
      $display("FAIL unmapped_no_enable: got re=%b we=%b ack=%b err=%b expected 0000", p_re, p_we, ack, err); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({err, ack, dout} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL unmapped_error: got err=%b ack=%b data=%h expected 1 0 0", err, ack, dout); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if (err !== 1'b0) begin
      $display("FAIL unmapped_single: got %b expected 0", err); n_fail++;
    end
  endtask

  task automatic test_timeout();
    int en = 1;
    int early = 0;
    int guard = 0;
    tick(); busy = 1'b1; put_req(1'b0, 4'hF, 24'h000020, 32'h0); sample();
    tick(); put_req(1'b1, 4'hF, 24'h000024, 32'hCAFE_F00D); sample();
    n_cmp++;
    if (p_re !== 1'b1) begin
      $display("FAIL timeout_enable_rise: got %b expected 1", p_re); n_fail++;
    end
    tick(); idle_bus(); sample();
    while (p_re && guard < 400) begin
      en++;
      if (err || ack) early++;
      tick(); sample();
      guard++;
    end
    n_cmp++;
    if (en !== 255) begin
      $display("FAIL timeout_enable_cycles: got %0d expected 255", en); n_fail++;
    end
    n_cmp++;
    if ({early, err, p_we} !== {32'd0, 1'b0, 1'b0}) begin
      $display("FAIL timeout_drop_cycle: got early=%0d err=%b we=%b expected 0 0 0", early, err, p_we); n_fail++;
    end
    busy = 1'b0;
    tick(); sample();
    n_cmp++;
    if ({err, ack, dout, p_we, p_adr} !== {1'b1, 1'b0, 32'h0, 1'b1, 24'h000024}) begin
      $display("FAIL timeout_error: got err=%b ack=%b data=%h we=%b adr=%h expected 1 0 0 1 000024",
               err, ack, dout, p_we, p_adr); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({ack, err} !== 2'b10) begin
      $display("FAIL timeout_next_ack: got ack=%b err=%b expected 1 0", ack, err); n_fail++;
    end
  endtask

  task automatic test_cyc_drop();
    tick(); busy = 1'b1; put_req(1'b1, 4'hF, 24'h000300, 32'h1111_1111); sample();
    tick(); put_req(1'b1, 4'hF, 24'h000304, 32'h2222_2222); sample();
    tick(); idle_bus(); sample();
    n_cmp++;
    if ({stall, p_we} !== 2'b11) begin
      $display("FAIL cycdrop_setup: got stall=%b we=%b expected 1 1", stall, p_we); n_fail++;
    end
    tick(); cyc = 1'b0; #1;
    n_cmp++;
    if ({p_we, p_re} !== 2'b00) begin
      $display("FAIL cycdrop_enables: got we=%b re=%b expected 0 0", p_we, p_re); n_fail++;
    end
    sample();
    tick(); sample();
    n_cmp++;
    if ({stall, ack, err, p_we} !== 4'b0) begin
      $display("FAIL cycdrop_flushed: got stall=%b ack=%b err=%b we=%b expected 0000", stall, ack, err, p_we); n_fail++;
    end
    tick(); cyc = 1'b1; busy = 1'b0; rdat = 32'h0BAD_F00D; put_req(1'b0, 4'hF, 24'h000044, 32'h0); sample();
    n_cmp++;
    if ({ack, err} !== 2'b00) begin
      $display("FAIL cycdrop_no_response: got ack=%b err=%b expected 0 0", ack, err); n_fail++;
    end
    tick(); idle_bus(); sample();
    n_cmp++;
    if ({p_re, p_adr} !== {1'b1, 24'h000044}) begin
      $display("FAIL cycdrop_restart_enable: got re=%b adr=%h expected 1 000044", p_re, p_adr); n_fail++;
    end
    tick(); sample();
    n_cmp++;
    if ({ack, err, dout} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
      $display("FAIL cycdrop_restart_ack: got ack=%b err=%b data=%h expected 1 0 0badf00d", ack, err, dout); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int resp = 0;
    tick(); busy = 1'b1; put_req(1'b0, 4'hF, 24'h000040, 32'h0); sample();
    tick(); idle_bus(); sample();
    tick(); rst = 1'b1;
    tick(); sample();
    n_cmp++;
    if ({p_re, p_we, stall} !== 3'b000) begin
      $display("FAIL rstmid_enables: got re=%b we=%b stall=%b expected 000", p_re, p_we, stall); n_fail++;
    end
    rst = 1'b0; busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      if (ack || err) resp++;
    end
    n_cmp++;
    if (resp !== 0) begin
      $display("FAIL rstmid_no_response: got %0d responses expected 0", resp); n_fail++;
    end
  endtask

  task automatic test_random();
    req_t pq[$];
    rsp_t rq[$];
    bit   done;
    int   issued;
    done = 1'b0;
    issued = 0;
    busy = 1'b0; cyc = 1'b1; idle_bus();
    fork
      begin
        bit   holding;
        int   guard;
        int   iters;
        logic [31:0] r;
        req_t q;
        rsp_t e;
        holding = 1'b0; guard = 0; iters = 0;
        while (issued < 60 && iters < 2000) begin
          tick();
          iters++;
          if (!holding) begin
            if ($urandom_range(0, 9) < 7) begin
              r = $urandom;
              put_req(r[0], r[7:4],
                      ($urandom_range(0, 9) == 0) ? 24'($urandom_range(4096, 24'hFFFFFF))
                                                  : 24'($urandom_range(0, 4095)),
                      $urandom);
            end else begin
              stb = 1'b0;
            end
          end
          sample();
          if (stb && !stall) begin
            q = '{we: we, sel: sel, adr: adr, data: wdat};
            if (adr >= 24'd4096) begin
              e = '{err: 1'b1, data: 32'h0};
            end else begin
              e = '{err: 1'b0, data: we ? 32'h0 : rd_model(adr & 24'hFFFFFC)};
              pq.push_back(q);
            end
            rq.push_back(e);
            issued++;
            holding = 1'b0;
          end else begin
            holding = stb;
          end
        end
        n_cmp++;
        if (issued !== 60) begin
          $display("FAIL rand_issue_budget: got %0d accepted expected 60", issued); n_fail++;
        end
        tick(); idle_bus();
        while (rq.size() != 0 && guard < 300) begin
          tick();
          guard++;
        end
        n_cmp++;
        if (rq.size() != 0) begin
          $display("FAIL rand_drain: got %0d outstanding expected 0", rq.size()); n_fail++;
        end
        done = 1'b1;
      end
      begin
        int   run;
        req_t e;
        run = 0;
        while (!done) begin
          @(posedge clk); #2;
          busy = (run >= 4) ? 1'b0 : 1'($urandom_range(0, 1));
          run  = busy ? run + 1 : 0;
          rdat = rd_model(p_adr);
          sample();
          if ((p_re || p_we) && !busy) begin
            n_cmp++;
            if (pq.size() == 0) begin
              $display("FAIL rand_unexpected_access: got adr=%h expected none", p_adr); n_fail++;
            end else begin
              e = pq.pop_front();
              if ({p_we, p_adr, p_sel} !== {e.we, e.adr & 24'hFFFFFC, e.sel} ||
                  (e.we && p_wdat !== e.data)) begin
                $display("FAIL rand_access: got we=%b adr=%h sel=%h data=%h expected we=%b adr=%h sel=%h data=%h",
                         p_we, p_adr, p_sel, p_wdat, e.we, e.adr & 24'hFFFFFC, e.sel, e.data); n_fail++;
              end
            end
          end
        end
      end
      begin
        rsp_t e;
        while (!done) begin
          sample();
          if (ack && err) begin
            n_cmp++;
            $display("FAIL rand_ack_and_err: got ack=1 err=1 expected at most one"); n_fail++;
          end
          if (ack || err) begin
            n_cmp++;
            if (rq.size() == 0) begin
              $display("FAIL rand_extra_response: got ack=%b err=%b expected none", ack, err); n_fail++;
            end else begin
              e = rq.pop_front();
              if ({err, dout} !== {e.err, e.data}) begin
                $display("FAIL rand_response: got err=%b data=%h expected err=%b data=%h",
                         err, dout, e.err, e.data); n_fail++;
              end
            end
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_busy();
    test_back_to_back();
    test_pipelined_stall();
    test_unmapped();
    test_timeout();
    test_cyc_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
